// File: rtl/hazard_scoreboard.sv
// Purpose: tracks the destination registers of in-flight EX/MEM/WB instructions and flags RAW hazards for decode.
// Latency: stall_id is combinational from the decode inputs and slot state; the slots advance one stage per clock.
// Backpressure: stall_id holds PC and IF/ID and bubbles ID/EX; mem_hold freezes all slots and the stall counter.
module hazard_scoreboard #(
  parameter bit FWD_EN    = 1'b1,  // EX/MEM forwarding present: only load-use in EX stalls
  parameter bit RF_BYPASS = 1'b1,  // register file write->read bypass: WB never stalls
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [2:0]       dec_wr_reg,
  input  logic             dec_wr_en,
  input  logic             dec_is_load,
  input  logic [2:0]       dec_rs,
  input  logic             dec_rs_vld,
  input  logic [2:0]       dec_rt,
  input  logic             dec_rt_vld,
  input  logic             mem_hold,
  input  logic             flush,
  output logic             stall_id,
  output logic [CNT_W-1:0] stall_cnt
);

  // One pending register write: valid flag, destination id, produced by a load.
  typedef struct packed {
    logic       vld;
    logic [2:0] rg;
    logic       ld;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic hz;

  // A slot hits when it holds a pending write to a register decode actually reads.
  // Using an OR over the two sources means rs==rt collapses into a single hit.
  function automatic logic src_hit(input slot_t s,
                                   input logic [2:0] rs, input logic rs_vld,
                                   input logic [2:0] rt, input logic rt_vld);
    logic m_rs;
    logic m_rt;
    m_rs = rs_vld && s.vld && (s.rg == rs);
    m_rt = rt_vld && s.vld && (s.rg == rt);
    return m_rs || m_rt;
  endfunction

  // Hazard detection against the in-flight slots; decode's own destination is never compared.
  always_comb begin
    hit_ex  = src_hit(ex_q,  dec_rs, dec_rs_vld, dec_rt, dec_rt_vld);
    hit_mem = src_hit(mem_q, dec_rs, dec_rs_vld, dec_rt, dec_rt_vld);
    hit_wb  = src_hit(wb_q,  dec_rs, dec_rs_vld, dec_rt, dec_rt_vld);
    hz      = 1'b0;
    if (FWD_EN) begin
      // Forwarding covers everything except a load whose data is not back yet.
      hz = hit_ex && ex_q.ld;
    end else begin
      hz = hit_ex || hit_mem || (!RF_BYPASS && hit_wb);
    end
    // A killed or absent decode instruction never stalls, nor does anything under reset.
    stall_id = dec_valid && !flush && !rst && hz;
  end

  // Next slot contents and stall counter; a memory hold freezes everything.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!mem_hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      // Only an instruction that really leaves decode this cycle and writes a register occupies EX.
      if (dec_valid && dec_wr_en && !stall_id && !flush) begin
        ex_d.vld = 1'b1;
        ex_d.rg  = dec_wr_reg;
        ex_d.ld  = dec_is_load;
      end
      // Saturate instead of wrapping so long runs still read as "a lot".
      if (stall_id && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Slot and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: directed bench for hazard_scoreboard in three parameterisations sharing one stimulus stream.
// Latency: stall_id compared a few ns after inputs change; counters compared just after the consuming edge.
// Backpressure: mem_hold and flush exercised directly as decode-side inputs.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [2:0] dec_wr_reg;
  logic       dec_wr_en;
  logic       dec_is_load;
  logic [2:0] dec_rs;
  logic       dec_rs_vld;
  logic [2:0] dec_rt;
  logic       dec_rt_vld;
  logic       mem_hold;
  logic       flush;

  logic        stall_a, stall_b, stall_c;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  a;
    logic  b;
    logic  c;
    string tag;
  } exp_t;

  exp_t sb[$];

  // A: forwarding + bypass, 4-bit counter. B: no forwarding, bypass. C: no forwarding, no bypass.
  hazard_scoreboard #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_wr_reg(dec_wr_reg), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_vld(dec_rs_vld), .dec_rt(dec_rt),
    .dec_rt_vld(dec_rt_vld), .mem_hold(mem_hold), .flush(flush), .stall_id(stall_a), .stall_cnt(cnt_a)
  );
  hazard_scoreboard #(.FWD_EN(1'b0), .RF_BYPASS(1'b1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_wr_reg(dec_wr_reg), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_vld(dec_rs_vld), .dec_rt(dec_rt),
    .dec_rt_vld(dec_rt_vld), .mem_hold(mem_hold), .flush(flush), .stall_id(stall_b), .stall_cnt(cnt_b)
  );
  hazard_scoreboard #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_wr_reg(dec_wr_reg), .dec_wr_en(dec_wr_en),
    .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_vld(dec_rs_vld), .dec_rt(dec_rt),
    .dec_rt_vld(dec_rt_vld), .mem_hold(mem_hold), .flush(flush), .stall_id(stall_c), .stall_cnt(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one decode instruction.
  task automatic drv(input logic v, input logic [2:0] wr, input logic we, input logic ld,
                     input logic [2:0] rs, input logic rsv, input logic [2:0] rt, input logic rtv);
    dec_valid   = v;
    dec_wr_reg  = wr;
    dec_wr_en   = we;
    dec_is_load = ld;
    dec_rs      = rs;
    dec_rs_vld  = rsv;
    dec_rt      = rt;
    dec_rt_vld  = rtv;
  endtask

  // Push expected stalls, compare once the combinational output settles, then consume one clock edge.
  task automatic step(input string tag, input logic ea, input logic eb, input logic ec);
    exp_t e;
    e.a = ea; e.b = eb; e.c = ec; e.tag = tag;
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    checks++;
    assert (stall_a === e.a) else begin
      errors++;
      $error("FAIL %s stall_a observed=%b expected=%b", e.tag, stall_a, e.a);
    end
    checks++;
    assert (stall_b === e.b) else begin
      errors++;
      $error("FAIL %s stall_b observed=%b expected=%b", e.tag, stall_b, e.b);
    end
    checks++;
    assert (stall_c === e.c) else begin
      errors++;
      $error("FAIL %s stall_c observed=%b expected=%b", e.tag, stall_c, e.c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int ea, input int eb, input int ec);
    checks++;
    assert (int'(cnt_a) === ea) else begin
      errors++;
      $error("FAIL %s cnt_a observed=%0d expected=%0d", tag, cnt_a, ea);
    end
    checks++;
    assert (int'(cnt_b) === eb) else begin
      errors++;
      $error("FAIL %s cnt_b observed=%0d expected=%0d", tag, cnt_b, eb);
    end
    checks++;
    assert (int'(cnt_c) === ec) else begin
      errors++;
      $error("FAIL %s cnt_c observed=%0d expected=%0d", tag, cnt_c, ec);
    end
  endtask

  initial begin
    rst = 1'b1; mem_hold = 1'b0; flush = 1'b0;
    drv(1'b1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    @(posedge clk);
    #1;

    // Reset held two cycles with a hazard-looking decode instruction.
    step("rst0", 0, 0, 0);
    step("rst1", 0, 0, 0);
    rst = 1'b0;
    chk_cnt("rst_cnt", 0, 0, 0);
    drv(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    step("post_rst_empty", 0, 0, 0);

    // Load-use on R2, both sources naming R2.
    drv(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step("ld_r2", 0, 0, 0);
    drv(1'b1, 3'd4, 1'b1, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1);
    step("use_r2_c1", 1, 1, 1);
    step("use_r2_c2", 0, 1, 1);
    step("use_r2_c3", 0, 0, 1);
    step("use_r2_c4", 0, 0, 0);
    chk_cnt("ld_use_cnt", 1, 2, 3);

    // Non-load producer R5, consumer on rt.
    drv(1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("addi_r5", 0, 0, 0);
    drv(1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1);
    step("use_r5_c1", 0, 1, 1);
    step("use_r5_c2", 0, 1, 1);
    step("use_r5_c3", 0, 0, 1);
    step("use_r5_c4", 0, 0, 0);
    chk_cnt("alu_use_cnt", 1, 4, 6);

    // Destination equal to own source is not a hazard.
    drv(1'b1, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    step("self_dst", 0, 0, 0);

    // Memory hold across a load-use stall.
    drv(1'b1, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step("ld_r1", 0, 0, 0);
    drv(1'b1, 3'd2, 1'b1, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0);
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("hold_%0d", i), 1, 1, 1);
    chk_cnt("hold_cnt", 1, 4, 6);
    mem_hold = 1'b0;
    step("unhold_c1", 1, 1, 1);
    step("unhold_c2", 0, 1, 1);
    step("unhold_c3", 0, 0, 1);
    step("unhold_c4", 0, 0, 0);
    chk_cnt("unhold_cnt", 2, 6, 9);

    // Flush beats a hazard on R7 and leaves a bubble in EX.
    drv(1'b1, 3'd7, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step("ld_r7", 0, 0, 0);
    drv(1'b1, 3'd7, 1'b1, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0);
    flush = 1'b1;
    step("flush_hz", 0, 0, 0);
    flush = 1'b0;
    drv(1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0);
    step("after_flush_c1", 0, 1, 1);
    step("after_flush_c2", 0, 0, 1);
    step("after_flush_c3", 0, 0, 0);
    chk_cnt("flush_cnt", 2, 7, 11);

    // Invalid decode never stalls; then reset in the middle of a stall.
    drv(1'b1, 3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step("ld_r6", 0, 0, 0);
    drv(1'b0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0);
    step("invalid_dec", 0, 0, 0);
    drv(1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0);
    step("use_r6", 0, 1, 1);
    chk_cnt("pre_rst_cnt", 2, 8, 12);
    rst = 1'b1;
    step("mid_rst", 0, 0, 0);
    rst = 1'b0;
    step("after_rst", 0, 0, 0);
    chk_cnt("mid_rst_cnt", 0, 0, 0);

    // Two slots holding R3: stall lasts until neither remains.
    drv(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("addi_r3_a", 0, 0, 0);
    step("addi_r3_b", 0, 0, 0);
    drv(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    step("multi_c1", 0, 1, 1);
    step("multi_c2", 0, 1, 1);
    step("multi_c3", 0, 0, 1);
    step("multi_c4", 0, 0, 0);
    chk_cnt("multi_cnt", 0, 2, 3);

    // Saturation of the 4-bit counter over 20 load-use stalls.
    drv(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("drain_%0d", i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 3'd1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      step($sformatf("sat_ld_%0d", i), 0, 0, 0);
      drv(1'b1, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0);
      step($sformatf("sat_use_%0d", i), 1, 1, 1);
      if (i == 14) chk_cnt("sat_cnt_15", 15, 17, 18);
    end
    chk_cnt("sat_cnt_20", 15, 22, 23);

    // A producer that does not write the register file never causes a stall.
    drv(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("drain2_%0d", i), 0, 0, 0);
    drv(1'b1, 3'd2, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    step("no_wr_prod", 0, 0, 0);
    drv(1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1);
    step("no_wr_use_c1", 0, 0, 0);
    step("no_wr_use_c2", 0, 0, 0);
    chk_cnt("final_cnt", 15, 22, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
